digest_serializer: RTL and testbench
====================================

Name: digest_serializer

Overview:
- Sits directly downstream of the BLAKE2 core and its simulator model.
- Captures the full-width digest when the core pulses digest_valid.
- Streams the first digest_len bytes out, little-endian, as BUS_WIDTH words over a valid/ready interface.
- Flags the last word and which of its bytes are valid. This is the digest-side counterpart of the controller's 32-bit input path.

Parameters:
- BUS_WIDTH, 32: output word width in bits; must be a multiple of 8.
- DIGEST_WIDTH, 512: width of the digest bus from the core, in bits; must be a multiple of BUS_WIDTH.
- LEN_WIDTH, 7: width of the digest_len field; must hold DIGEST_WIDTH/8.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- digest_valid, input, 1: one-cycle pulse from the core; digest is valid in that cycle.
- digest, input, DIGEST_WIDTH: hash result; byte i is digest[8i+7:8i].
- digest_len, input, LEN_WIDTH: number of digest bytes to emit; sampled together with digest_valid.
- dout, output, BUS_WIDTH: output word; byte j of word k is digest byte k*BUS_WIDTH/8+j, placed at dout[8j+7:8j].
- dout_valid, output, 1: dout, dout_keep and dout_last are valid.
- dout_ready, input, 1: consumer accepts the word; a transfer occurs when dout_valid and dout_ready are both high.
- dout_last, output, 1: the current word is the final word of this digest.
- dout_keep, output, BUS_WIDTH/8: byte-valid mask for the current word.
- busy, output, 1: high while a digest is held or being sent.
- overrun, output, 1: one-cycle pulse when a digest_valid is dropped.

Behaviour:
- Reset:
  - All outputs are 0 one cycle after reset is sampled high; state returns to IDLE.
  - The shadow register and counters are cleared.
  - Reset has priority over everything, including mid-stream; any partial digest is discarded and no dout_last is produced.
- State machine:
  - IDLE: dout_valid=0, busy=0. digest_valid=1 -> capture, go to SEND.
  - SEND: dout_valid=1, busy=1. A transfer on the last word -> IDLE, unless a new digest is captured in that same cycle, in which case stay in SEND.
- Capture:
  - Latch digest into the shadow register.
  - Effective length L = digest_len, except: digest_len=0 -> L=DIGEST_WIDTH/8; digest_len>DIGEST_WIDTH/8 -> L=DIGEST_WIDTH/8.
  - Word count W = ceil(L/(BUS_WIDTH/8)). Word index resets to 0.
- Latency: digest_valid in cycle N gives dout_valid=1 with word 0 in cycle N+1.
- Transfer:
  - On dout_valid and dout_ready, the index increments and the shadow register shifts right by BUS_WIDTH.
  - One word per cycle when dout_ready is held high.
- Backpressure: while dout_valid=1 and dout_ready=0, dout, dout_keep and dout_last hold stable.
- dout_last = 1 exactly when index = W-1.
- dout_keep:
  - All ones for every non-last word.
  - Last word: low (L mod BUS_WIDTH/8) bits set, or all ones if the remainder is 0.
- Bytes of dout outside dout_keep are driven 0.
- Acceptance of a new digest:
  - Accepted in IDLE.
  - Also accepted in the cycle of the final transfer (dout_valid, dout_ready, dout_last all high); the new word 0 appears the next cycle, giving back-to-back digests with no bubble.
  - digest_valid at any other time in SEND: the digest is ignored, overrun pulses for 1 cycle, and the current stream continues unchanged.
- busy = (state == SEND).

Test Plan:
Common stimulus: digest byte i = i for i = 0..63, so digest[31:0] = 0x03020100.
- Reset, then digest_len=64 with dout_ready held at 1 -> dout_valid rises 1 cycle after digest_valid. Expect 16 words 0x03020100 .. 0x3F3E3D3C, dout_keep=0xF on all, dout_last only on word 15, busy falls the cycle after.
- digest_len=11 -> 3 words: 0x03020100, 0x07060504, 0x000A0908. dout_keep = 0xF, 0xF, 0x7. dout_last on word 2.
- digest_len=0 and digest_len=100 -> each behaves identically to 64 (16 words, last word keep=0xF).
- digest_len=20 with dout_ready toggling 1,0,0,1,... -> dout holds stable during the 0 cycles. Expect exactly 5 transfers, in order; no word duplicated or skipped.
- digest_valid in the middle of a stream -> overrun pulses for 1 cycle and the original stream completes intact. digest_valid coincident with the final transfer -> the new word 0 appears the next cycle and overrun stays 0.
- reset asserted for 1 cycle after the 3rd transfer of a len=64 digest -> the next cycle has dout_valid=0, busy=0 and all outputs 0. A following digest (len=8) streams 2 fresh words correctly.

Source files
------------

// File: rtl/digest_serializer.sv
// Captures a full-width digest from the hash core and streams its first bytes
// out little-endian as BUS_WIDTH words over a valid/ready interface.
module digest_serializer #(
  parameter int BUS_WIDTH    = 32,
  parameter int DIGEST_WIDTH = 512,
  parameter int LEN_WIDTH    = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      digest_valid,
  input  logic [DIGEST_WIDTH-1:0]   digest,
  input  logic [LEN_WIDTH-1:0]      digest_len,
  output logic [BUS_WIDTH-1:0]      dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_last,
  output logic [BUS_WIDTH/8-1:0]    dout_keep,
  output logic                      busy,
  output logic                      overrun
);

  // state | meaning
  // IDLE  | nothing held, waiting for digest_valid
  // SEND  | shadow register holds a digest, words being offered on dout

  localparam int BPW       = BUS_WIDTH / 8;
  localparam int MAX_BYTES = DIGEST_WIDTH / 8;
  localparam int WORDS     = DIGEST_WIDTH / BUS_WIDTH;
  localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state, state_next;
  logic [DIGEST_WIDTH-1:0] shadow;
  logic [IDX_W-1:0]        idx, last_idx, cap_last_idx;
  logic [BPW-1:0]          last_keep, cap_last_keep;
  logic [LEN_WIDTH-1:0]    len_eff, len_rem;
  logic                    overrun_q;
  logic                    send, xfer, on_last, final_xfer, capture;

  assign send       = (state == SEND);
  assign xfer       = send && dout_ready;
  assign on_last    = (idx == last_idx);
  assign final_xfer = xfer && on_last;
  assign capture    = digest_valid && (!send || final_xfer);

  // Zero and oversize lengths both mean "the whole digest".
  always_comb begin
    len_eff = digest_len;
    if (digest_len == '0 || digest_len > LEN_WIDTH'(MAX_BYTES))
      len_eff = LEN_WIDTH'(MAX_BYTES);
    len_rem       = len_eff % LEN_WIDTH'(BPW);
    cap_last_idx  = IDX_W'((len_eff - LEN_WIDTH'(1)) / LEN_WIDTH'(BPW));
    cap_last_keep = {BPW{1'b1}};
    if (len_rem != '0)
      cap_last_keep = ~({BPW{1'b1}} << len_rem);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = SEND;
      SEND:    if (final_xfer && !capture) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      idx       <= '0;
      last_idx  <= '0;
      last_keep <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= digest_valid && !capture;
      if (capture) begin
        shadow    <= digest;
        idx       <= '0;
        last_idx  <= cap_last_idx;
        last_keep <= cap_last_keep;
      end else if (xfer) begin
        shadow <= shadow >> BUS_WIDTH;
        idx    <= idx + IDX_W'(1);
      end
    end
  end

  // Outputs are gated by SEND so residual shadow bytes never leak while idle.
  always_comb begin
    dout_keep = '0;
    if (send) dout_keep = on_last ? last_keep : {BPW{1'b1}};
    for (int j = 0; j < BPW; j++)
      dout[8*j +: 8] = dout_keep[j] ? shadow[8*j +: 8] : 8'h00;
  end

  assign dout_valid = send;
  assign busy       = send;
  assign dout_last  = send && on_last;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_digest_serializer.sv
// Randomized bench for digest_serializer; a byte-level queue model predicts every
// word, keep mask, last flag, busy and overrun.
module tb_digest_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         digest_valid;
  logic [511:0] digest;
  logic [6:0]   digest_len;
  logic [31:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic [3:0]   dout_keep;
  logic         busy;
  logic         overrun;

  digest_serializer #(.BUS_WIDTH(32), .DIGEST_WIDTH(512), .LEN_WIDTH(7)) dut (
    .clk(clk), .reset(reset), .digest_valid(digest_valid), .digest(digest),
    .digest_len(digest_len), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .dout_keep(dout_keep),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] dig_bytes[64];
  logic       exp_ovr;
  int         n_checks;
  int         n_errors;
  int         n_xfers;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pack_digest();
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[8*i +: 8] = dig_bytes[i];
    return d;
  endfunction

  // Builds the expected words for one digest straight from the byte rules.
  task automatic push_words(input int len);
    int l, w;
    word_t wd;
    l = len;
    if (l == 0 || l > 64) l = 64;
    w = (l + 3) / 4;
    for (int k = 0; k < w; k++) begin
      wd.data = '0;
      wd.keep = '0;
      for (int j = 0; j < 4; j++) begin
        if (k*4 + j < l) begin
          wd.data[8*j +: 8] = dig_bytes[k*4 + j];
          wd.keep[j] = 1'b1;
        end
      end
      wd.last = (k == w - 1);
      exp_q.push_back(wd);
    end
  endtask

  // One clock: drive inputs, check current outputs, advance model, wait a cycle.
  task automatic cycle(input logic rdy, input logic dv, input int len, input logic rst);
    int  sz;
    logic fin, acc;
    reset        = rst;
    dout_ready   = rdy;
    digest_valid = dv;
    digest_len   = 7'(len);
    digest       = pack_digest();
    sz = exp_q.size();
    check_val("dout_valid", 32'(dout_valid), 32'(sz != 0));
    check_val("busy", 32'(busy), 32'(sz != 0));
    check_val("overrun", 32'(overrun), 32'(exp_ovr));
    if (sz != 0) begin
      check_val("dout", dout, exp_q[0].data);
      check_val("dout_keep", 32'(dout_keep), 32'(exp_q[0].keep));
      check_val("dout_last", 32'(dout_last), 32'(exp_q[0].last));
    end else begin
      check_val("idle_dout", dout, 32'h0);
      check_val("idle_keep", 32'(dout_keep), 32'h0);
      check_val("idle_last", 32'(dout_last), 32'h0);
    end
    if (rst) begin
      exp_q.delete();
      exp_ovr = 1'b0;
    end else begin
      fin = 1'b0;
      if (rdy && sz != 0) begin
        fin = exp_q[0].last;
        void'(exp_q.pop_front());
        n_xfers++;
      end
      acc = dv && (sz == 0 || fin);
      if (acc) push_words(len);
      exp_ovr = dv && !acc;
    end
    @(negedge clk);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 64; i++) dig_bytes[i] = 8'(i);
  endtask

  task automatic set_random();
    for (int i = 0; i < 64; i++) dig_bytes[i] = 8'($urandom_range(255, 0));
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_xfers = 0; exp_ovr = 1'b0;
    set_ramp();
    reset = 1'b1; digest_valid = 1'b0; dout_ready = 1'b0; digest_len = '0;
    digest = pack_digest();
    @(negedge clk); @(negedge clk);

    // Full 64-byte digest, ready held high.
    cycle(1, 1, 64, 0);
    check_val("s1_word0", dout, 32'h03020100);
    for (int i = 0; i < 18; i++) cycle(1, 0, 0, 0);

    // Short digest with partial last word.
    cycle(1, 1, 11, 0);
    for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0);
    check_val("s2_last_data", dout, 32'h000A0908);
    check_val("s2_last_keep", 32'(dout_keep), 32'h7);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);

    // Zero and oversize lengths mean the whole digest.
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 18; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 100, 0);
    for (int i = 0; i < 18; i++) cycle(1, 0, 0, 0);

    // Backpressure pattern 1,0,0 repeating.
    cycle(0, 1, 20, 0);
    n_xfers = 0;
    for (int i = 0; i < 21; i++) cycle((i % 3) == 0, 0, 0, 0);
    check_val("s4_xfers", 32'(n_xfers), 32'd5);

    // Dropped digest mid-stream, then one accepted on the final transfer.
    cycle(1, 1, 64, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    set_random();
    cycle(1, 1, 32, 0);
    check_val("s5_overrun", 32'(overrun), 32'h1);
    for (int i = 0; i < 40 && exp_q.size() > 1; i++) cycle(1, 0, 0, 0);
    check_val("s5_on_last", 32'(dout_last), 32'h1);
    cycle(1, 1, 12, 0);
    check_val("s5_no_overrun", 32'(overrun), 32'h0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);

    // Reset mid-stream discards the digest.
    set_ramp();
    cycle(1, 1, 64, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    check_val("s6_rst_valid", 32'(dout_valid), 32'h0);
    cycle(1, 1, 8, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7, 0) == 0) set_random();
      cycle($urandom_range(3, 0) != 0, $urandom_range(9, 0) == 0,
            int'($urandom_range(127, 0)), $urandom_range(199, 0) == 0);
    end
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
